// File: rtl/response_pkg.sv
// Shared types and constants for the response scheduler and the sources that
// feed it two-byte frames (code, data).
package response_pkg;

  localparam int BYTE_W    = 8;
  localparam int FRAME_LEN = 2;
  localparam int ST_W      = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SEND_CODE = 3'd2,
    ST_WAIT_CODE = 3'd3,
    ST_SEND_DATA = 3'd4,
    ST_WAIT_DATA = 3'd5,
    ST_ACK       = 3'd6
  } state_t;

  // Response codes placed in the first byte of a frame by the sources.
  localparam logic [BYTE_W-1:0] RSP_SENSOR = 8'h01;
  localparam logic [BYTE_W-1:0] RSP_STATUS = 8'h10;
  localparam logic [BYTE_W-1:0] RSP_NACK   = 8'h15;
  localparam logic [BYTE_W-1:0] RSP_ERROR  = 8'hE0;

  // Round-robin successor of a requester index among n requesters.
  function automatic logic [2:0] next_index(input logic [2:0] idx, input int n);
    return (int'(idx) == n - 1) ? 3'd0 : idx + 3'd1;
  endfunction

endpackage

// File: rtl/response_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the pointer,
// wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [2:0]         pointer,
  output logic [NUM_REQ-1:0] grant_onehot,
  output logic [2:0]         grant_idx,
  output logic               any
);

  int cand;

  // Scan from the farthest offset down so the candidate nearest the pointer
  // is written last and therefore wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional write; otherwise the tool infers a latch.
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(pointer) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req[cand]) begin
        grant_onehot       = '0;
        grant_onehot[cand] = 1'b1;
        grant_idx          = 3'(cand);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/response_scheduler.sv
// Shares one UART transmitter among several response sources: round-robin
// grant, two-byte frame sequencing, source acknowledge and a per-byte watchdog.
module response_scheduler
  import response_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_code,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ack,
  output logic                      tx_start,
  output logic [BYTE_W-1:0]         tx_byte,
  input  logic                      tx_done,
  output logic                      busy,
  output logic [2:0]                grant_id,
  output logic                      timeout_err
);

  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [2:0]          ptr;
  logic [2:0]          win_idx;
  logic [NUM_REQ-1:0]  win_mask;
  logic [BYTE_W-1:0]   data_q;
  logic [15:0]         wd_cnt;

  logic [NUM_REQ-1:0]  arb_onehot;
  logic [2:0]          arb_idx;
  logic                arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (req_valid),
    .pointer      (ptr),
    .grant_onehot (arb_onehot),
    .grant_idx    (arb_idx),
    .any          (arb_any)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      win_idx     <= '0;
      win_mask    <= '0;
      data_q      <= '0;
      wd_cnt      <= '0;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every branch
      // sees the values from before this edge; the pulse outputs default low
      // here and are raised only in the branch that owns them.
      tx_start    <= 1'b0;
      req_ack     <= '0;
      timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            win_idx  <= arb_idx;
            win_mask <= arb_onehot;
            busy     <= 1'b1;
            state    <= ST_LOAD;
          end
        end

        // The frame is captured here; the code byte goes straight into the
        // output register, the data byte waits in data_q.
        ST_LOAD: begin
          grant_id <= win_idx;
          data_q   <= req_data[int'(win_idx) * BYTE_W +: BYTE_W];
          tx_byte  <= req_code[int'(win_idx) * BYTE_W +: BYTE_W];
          tx_start <= 1'b1;
          state    <= ST_SEND_CODE;
        end

        ST_SEND_CODE: begin
          wd_cnt <= '0;
          state  <= ST_WAIT_CODE;
        end

        ST_SEND_DATA: begin
          wd_cnt <= '0;
          state  <= ST_WAIT_DATA;
        end

        // tx_done is checked before the watchdog so a completion landing on
        // the expiry cycle still counts as a normal finish.
        ST_WAIT_CODE, ST_WAIT_DATA: begin
          if (tx_done) begin
            if (state == ST_WAIT_CODE) begin
              tx_byte  <= data_q;
              tx_start <= 1'b1;
              state    <= ST_SEND_DATA;
            end else begin
              req_ack <= win_mask;
              state   <= ST_ACK;
            end
          end else if (wd_cnt == WD_LIMIT) begin
            // Drop the frame but still ack the source so it cannot hang.
            timeout_err <= 1'b1;
            req_ack     <= win_mask;
            tx_byte     <= '0;
            state       <= ST_ACK;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
        end

        ST_ACK: begin
          ptr   <= next_index(grant_id, NUM_REQ);
          busy  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_response_scheduler.sv
// Scoreboard bench for response_scheduler: expected bytes, grants and acks are
// queued at request time and popped as the DUT emits tx_start / req_ack.
module tb_response_scheduler;
  import response_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic            clock = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_code;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ack;
  logic            tx_start;
  logic [7:0]      tx_byte;
  logic            tx_done;
  logic            busy;
  logic [2:0]      grant_id;
  logic            timeout_err;

  response_scheduler #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_code    (req_code),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  always #5 clock = ~clock;

  logic [7:0]    exp_byte[$];
  logic [2:0]    exp_grant[$];
  logic [NR-1:0] exp_ack[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  int to_seen = 0;
  int to_cyc = 0;
  int byte_idx = 0;
  int uart_delay = 3;
  int ucnt = 0;
  bit inflight = 1'b0;
  logic [7:0] held = '0;
  int model_ptr = 0;
  logic [7:0] code_v[NR];
  logic [7:0] data_v[NR];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int w);
    logic [NR-1:0] m;
    m    = '0;
    m[w] = 1'b1;
    return m;
  endfunction

  // One clock: sample outputs at the falling edge, then drive the UART model
  // and the requesters for the next rising edge.
  task automatic tick();
    @(negedge clock);
    cyc++;
    tx_done = 1'b0;
    if (timeout_err) begin
      to_seen++;
      to_cyc = cyc;
      check("to_byte_clr", 32'(tx_byte), 0);
    end
    if (tx_start) begin
      if (exp_byte.size() == 0) begin
        check("unexp_start", 32'(tx_start), 0);
      end else begin
        check("tx_byte", 32'(tx_byte), 32'(exp_byte.pop_front()));
        check("grant_id", 32'(grant_id), 32'(exp_grant.pop_front()));
        check("busy_tx", 32'(busy), 1);
      end
      if (byte_idx == 0) start_cyc = cyc;
      else check("lat_data", cyc - done_cyc, 1);
      byte_idx++;
      inflight = 1'b1;
      ucnt     = uart_delay;
      held     = tx_byte;
    end else if (inflight) begin
      if (ucnt == 0) begin
        if (!timeout_err) check("tx_hold", 32'(tx_byte), 32'(held));
        tx_done  = 1'b1;
        inflight = 1'b0;
        done_cyc = cyc;
      end else begin
        ucnt--;
      end
    end
    if (req_ack != '0) begin
      if (exp_ack.size() == 0) check("unexp_ack", 32'(req_ack), 0);
      else check("req_ack", 32'(req_ack), 32'(exp_ack.pop_front()));
      if (!timeout_err) check("lat_ack", cyc - done_cyc, 1);
      req_valid = req_valid & ~req_ack;
      byte_idx  = 0;
    end
  endtask

  // Raise requests and queue the expected service order from a pointer model.
  task automatic post(input logic [NR-1:0] mask, input bit drop_data);
    logic [NR-1:0] pend;
    int w;
    pend = mask;
    for (int i = 0; i < NR; i++) begin
      if (mask[i]) begin
        req_code[8*i +: 8] = code_v[i];
        req_data[8*i +: 8] = data_v[i];
      end
    end
    req_valid = req_valid | mask;
    while (pend != '0) begin
      w = model_ptr;
      while (!pend[w]) w = (w + 1) % NR;
      exp_byte.push_back(code_v[w]);
      exp_grant.push_back(3'(w));
      if (!drop_data) begin
        exp_byte.push_back(data_v[w]);
        exp_grant.push_back(3'(w));
      end
      exp_ack.push_back(onehot(w));
      model_ptr = (w + 1) % NR;
      pend[w]   = 1'b0;
    end
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int k = 0; k < max_cycles; k++) begin
      if (exp_ack.size() == 0 && busy == 1'b0) break;
      tick();
    end
    check("drain_acks", exp_ack.size(), 0);
    check("drain_bytes", exp_byte.size(), 0);
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    int t0;
    int to_base;
    reset_n   = 1'b0;
    req_valid = '0;
    req_code  = '0;
    req_data  = '0;
    tx_done   = 1'b0;
    repeat (3) tick();
    check("rst_req_ack", 32'(req_ack), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_byte", 32'(tx_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    #2 reset_n = 1'b1;
    tick();

    // All four sources at once from pointer 0: served 0,1,2,3.
    code_v = '{8'h10, 8'h11, 8'h12, 8'h13};
    data_v = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    post(4'b1111, 1'b0);
    wait_idle(300);

    // Single source, first-byte latency.
    code_v[0] = RSP_SENSOR;
    data_v[0] = 8'h2A;
    t0 = cyc;
    post(4'b0001, 1'b0);
    wait_idle(100);
    check("lat_code", start_cyc - t0, 2);

    // Source 2 alone moves the pointer to 3; then 1 and 3 must go 3 first.
    code_v[2] = RSP_STATUS;
    data_v[2] = 8'h55;
    post(4'b0100, 1'b0);
    wait_idle(100);
    code_v[1] = 8'h21; data_v[1] = 8'hB1;
    code_v[3] = 8'h23; data_v[3] = 8'hB3;
    post(4'b1010, 1'b0);
    wait_idle(200);

    // Stalled transmitter: code byte only, watchdog abort, source still acked.
    to_base    = to_seen;
    uart_delay = TO;
    code_v[0]  = RSP_ERROR;
    data_v[0]  = 8'h77;
    post(4'b0001, 1'b1);
    wait_idle(200);
    check("to_count", to_seen - to_base, 1);
    check("to_latency", to_cyc - start_cyc, 17);

    // tx_done on the expiry cycle of both bytes: normal completion.
    uart_delay = TO - 1;
    code_v[2]  = RSP_NACK;
    data_v[2]  = 8'h3C;
    post(4'b0100, 1'b0);
    wait_idle(200);
    check("to_simult", to_seen - to_base, 1);
    uart_delay = 3;

    // Reset during WAIT_DATA of a frame from source 3.
    code_v[3] = 8'h33;
    data_v[3] = 8'hC3;
    post(4'b1000, 1'b0);
    for (int k = 0; k < 100; k++) begin
      tick();
      if (byte_idx == 2) break;
    end
    check("pre_rst_phase", byte_idx, 2);
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 0);
    check("arst_tx_byte", 32'(tx_byte), 0);
    check("arst_grant_id", 32'(grant_id), 0);
    check("arst_req_ack", 32'(req_ack), 0);
    check("arst_tx_start", 32'(tx_start), 0);
    check("arst_timeout", 32'(timeout_err), 0);
    tx_done   = 1'b0;
    inflight  = 1'b0;
    req_valid = '0;
    byte_idx  = 0;
    model_ptr = 0;
    exp_byte.delete();
    exp_grant.delete();
    exp_ack.delete();
    repeat (3) tick();
    #2 reset_n = 1'b1;
    code_v[1] = 8'h41; data_v[1] = 8'hD1;
    code_v[3] = 8'h43; data_v[3] = 8'hD3;
    post(4'b1010, 1'b0);
    wait_idle(200);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "global timeout");
  end

endmodule
